// File: rtl/cpu_types_pkg.sv
// Shared types for the data cache: address split, controller states and frame write operations.
package cpu_types_pkg;

  localparam int DTAG_W = 26;
  localparam int DIDX_W = 4;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic [DTAG_W-1:0] tag;
    logic [DIDX_W-1:0] idx;
    logic [1:0]        bytoff;
  } dcachef_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WB    = 3'd1,
    FETCH = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } dcache_state_t;

  typedef enum logic [1:0] {
    FOP_NONE  = 2'd0,
    FOP_FILL  = 2'd1,
    FOP_STORE = 2'd2,
    FOP_CLEAN = 2'd3
  } frame_op_t;

endpackage

// File: rtl/dcache_frames.sv
// Frame storage for the data cache: valid/dirty flags, tags and data words,
// one combinational read port and one write port selected by frame_op_t.
module dcache_frames import cpu_types_pkg::*; #(
  parameter int SETS = 16,
  parameter int IW   = 4,
  parameter int TW   = 26
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [IW-1:0] rd_idx,
  output logic          rd_valid,
  output logic          rd_dirty,
  output logic [TW-1:0] rd_tag,
  output word_t         rd_data,
  input  frame_op_t     wr_op,
  input  logic [IW-1:0] wr_idx,
  input  logic [TW-1:0] wr_tag,
  input  word_t         wr_data
);

  logic [SETS-1:0] valid_reg;
  logic [SETS-1:0] dirty_reg;
  logic [TW-1:0]   tag_mem  [SETS];
  word_t           data_mem [SETS];

  // Flags need a reset; tag/data are only meaningful behind a valid flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_reg <= '0;
      dirty_reg <= '0;
    end else begin
      case (wr_op)
        FOP_FILL: begin
          valid_reg[wr_idx] <= 1'b1;
          dirty_reg[wr_idx] <= 1'b0;
        end
        FOP_STORE: dirty_reg[wr_idx] <= 1'b1;
        FOP_CLEAN: dirty_reg[wr_idx] <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_op == FOP_FILL)
      tag_mem[wr_idx] <= wr_tag;
    if (wr_op == FOP_FILL || wr_op == FOP_STORE)
      data_mem[wr_idx] <= wr_data;
  end

  assign rd_valid = valid_reg[rd_idx];
  assign rd_dirty = dirty_reg[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back data cache with one-word blocks and halt-triggered flush.
// Optional DCACHE_STATS_EN adds hit_count/miss_count outputs.
module dcache import cpu_types_pkg::*; #(
  parameter int SETS = 16
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  dmemREN,
  input  logic  dmemWEN,
  input  word_t dmemaddr,
  input  word_t dmemstore,
  input  logic  halt,
  output word_t dmemload,
  output logic  dhit,
  output logic  flushed,
  output logic  dREN,
  output logic  dWEN,
  output word_t daddr,
  output word_t dstore,
  input  word_t dload,
  input  logic  dwait
`ifdef DCACHE_STATS_EN
  ,
  output word_t hit_count,
  output word_t miss_count
`endif
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;

  dcache_state_t state_reg, state_next;
  logic [IW-1:0] flush_cnt_reg, flush_cnt_next;

  logic [IW-1:0] req_idx, rd_idx;
  logic [TW-1:0] req_tag, rd_tag;
  logic          rd_valid, rd_dirty;
  word_t         rd_data;
  frame_op_t     wr_op;
  word_t         wr_data;
  logic          req, hit, last_frame;
  logic          unused_byte_offset;

  assign req_idx            = dmemaddr[IW+1:2];
  assign req_tag            = dmemaddr[31:IW+2];
  assign unused_byte_offset = ^dmemaddr[1:0];
  assign req                = dmemREN | dmemWEN;
  assign rd_idx             = (state_reg == FLUSH) ? flush_cnt_reg : req_idx;
  assign last_frame         = (flush_cnt_reg == IW'(SETS - 1));

  // Halt takes priority over a pending request in IDLE, so no hit while halting.
  assign hit = !RST && (state_reg == IDLE) && !halt && req && rd_valid && (rd_tag == req_tag);

  dcache_frames #(
    .SETS (SETS),
    .IW   (IW),
    .TW   (TW)
  ) u_frames (
    .CLK      (CLK),
    .RST      (RST),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_op    (wr_op),
    .wr_idx   (rd_idx),
    .wr_tag   (req_tag),
    .wr_data  (wr_data)
  );

  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    wr_op          = FOP_NONE;
    wr_data        = dmemstore;
    dREN           = 1'b0;
    dWEN           = 1'b0;
    daddr          = '0;
    dstore         = '0;
    case (state_reg)
      IDLE: begin
        if (halt) begin
          state_next = FLUSH;
        end else if (req) begin
          if (hit) begin
            if (dmemWEN) wr_op = FOP_STORE;
          end else if (rd_valid && rd_dirty) begin
            state_next = WB;
          end else begin
            state_next = FETCH;
          end
        end
      end
      WB: begin
        dWEN   = 1'b1;
        daddr  = {rd_tag, rd_idx, 2'b00};
        dstore = rd_data;
        if (!dwait) begin
          wr_op      = FOP_CLEAN;
          state_next = FETCH;
        end
      end
      FETCH: begin
        dREN  = 1'b1;
        daddr = {dmemaddr[31:2], 2'b00};
        if (!dwait) begin
          wr_op      = FOP_FILL;
          wr_data    = dload;
          state_next = IDLE;
        end
      end
      FLUSH: begin
        if (rd_valid && rd_dirty) begin
          dWEN   = 1'b1;
          daddr  = {rd_tag, rd_idx, 2'b00};
          dstore = rd_data;
        end
        // Clean frames retire immediately; dirty ones wait for the write to land.
        if (!(rd_valid && rd_dirty) || !dwait) begin
          if (rd_valid && rd_dirty) wr_op = FOP_CLEAN;
          flush_cnt_next = flush_cnt_reg + 1'b1;
          if (last_frame) state_next = DONE;
        end
      end
      DONE: ;
      default: state_next = IDLE;
    endcase
    if (RST) begin
      dREN   = 1'b0;
      dWEN   = 1'b0;
      daddr  = '0;
      dstore = '0;
      wr_op  = FOP_NONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      flush_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  assign dhit     = hit;
  assign dmemload = hit ? rd_data : '0;
  assign flushed  = !RST && (state_reg == DONE);

`ifdef DCACHE_STATS_EN
  logic  fill_reg;
  word_t hit_count_reg, miss_count_reg;

  // The hit right after a fill completes the original miss and is not counted again.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fill_reg       <= 1'b0;
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      fill_reg <= (wr_op == FOP_FILL);
      if (state_reg == IDLE && (state_next == WB || state_next == FETCH))
        miss_count_reg <= miss_count_reg + 1'b1;
      if (hit && !fill_reg)
        hit_count_reg <= hit_count_reg + 1'b1;
    end
  end

  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;
`endif

endmodule
